proc_ctrl_unit: RTL

//  Parametrised multicycle control FSM for the Project B processor, successor to the fixed 16-bit unit.

---
 rtl/proc_ctrl_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/proc_ctrl_unit.sv
// Multicycle control FSM for the Project B processor.
// Fetches over a req/ack port, decodes, and drives DataPath controls.
module proc_ctrl_unit #(
    parameter int PC_W = 8,
    parameter int D_AW = 8,
    parameter int RF_AW = 4,
    localparam int IR_W = 4 + D_AW + RF_AW
) (
    input  logic             clk,
    input  logic             Reset,
    output logic             I_Req,
    output logic [PC_W-1:0]  I_Addr,
    input  logic             I_Ack,
    input  logic [IR_W-1:0]  I_Data,
    input  logic             Zero,
    input  logic             Resume,
    output logic [PC_W-1:0]  PC_Out,
    output logic [IR_W-1:0]  IR_Out,
    output logic [3:0]       State,
    output logic [3:0]       NextState,
    output logic [D_AW-1:0]  D_Addr,
    output logic             D_Wr,
    output logic             RF_s,
    output logic             RF_W_en,
    output logic [RF_AW-1:0] RF_Ra_Addr,
    output logic [RF_AW-1:0] RF_Rb_Addr,
    output logic [RF_AW-1:0] RF_W_Addr,
    output logic [1:0]       ALU_Sel,
    output logic             Halted
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_JZ     = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;
    localparam logic [3:0] OP_JZ    = 4'd6;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    // Field overlap (F1/F2 inside ADDR, jump target from ADDR) needs these.
    if (D_AW < 2 * RF_AW || D_AW < PC_W) begin : g_bad_params
        $error("proc_ctrl_unit: D_AW must be >= 2*RF_AW and >= PC_W");
    end

    state_t            state_q;
    state_t            state_d;
    logic [PC_W-1:0]   pc_q;
    logic [IR_W-1:0]   ir_q;

    logic [3:0]        op_f;
    logic [D_AW-1:0]   addr_f;
    logic [RF_AW-1:0]  f0;
    logic [RF_AW-1:0]  f1;
    logic [RF_AW-1:0]  f2;

    assign op_f   = ir_q[IR_W-1:IR_W-4];
    assign addr_f = ir_q[IR_W-5:RF_AW];
    assign f0     = ir_q[RF_AW-1:0];
    assign f1     = ir_q[2*RF_AW-1:RF_AW];
    assign f2     = ir_q[3*RF_AW-1:2*RF_AW];

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_INIT;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && I_Ack) begin
                ir_q <= I_Data;
                pc_q <= pc_q + PC_W'(1);
            end else if (state_q == S_JZ && Zero) begin
                pc_q <= addr_f[PC_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = I_Ack ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (op_f)
                    OP_NOOP:  state_d = S_NOOP;
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
                    OP_JZ:    state_d = S_JZ;
                    default:  state_d = S_NOOP;
                endcase
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_NOOP,
            S_LOAD_B,
            S_STORE,
            S_ADD,
            S_SUB,
            S_JZ:     state_d = S_FETCH;
            S_HALT:   state_d = Resume ? S_FETCH : S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    always_comb begin
        I_Req      = 1'b0;
        D_Addr     = '0;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_en    = 1'b0;
        RF_Ra_Addr = '0;
        RF_Rb_Addr = '0;
        RF_W_Addr  = '0;
        ALU_Sel    = ALU_PASS;
        Halted     = 1'b0;
        unique case (state_q)
            S_FETCH: I_Req = 1'b1;
            // Sync RAM read is issued here and lands in LOAD_B.
            S_LOAD_A: begin
                D_Addr = addr_f;
                RF_s   = 1'b1;
            end
            S_LOAD_B: begin
                D_Addr    = addr_f;
                RF_s      = 1'b1;
                RF_W_en   = 1'b1;
                RF_W_Addr = f0;
            end
            S_STORE: begin
                D_Addr     = addr_f;
                RF_Ra_Addr = f0;
                D_Wr       = 1'b1;
            end
            S_ADD: begin
                RF_Ra_Addr = f2;
                RF_Rb_Addr = f1;
                ALU_Sel    = ALU_ADD;
                RF_W_en    = 1'b1;
                RF_W_Addr  = f0;
            end
            S_SUB: begin
                RF_Ra_Addr = f2;
                RF_Rb_Addr = f1;
                ALU_Sel    = ALU_SUB;
                RF_W_en    = 1'b1;
                RF_W_Addr  = f0;
            end
            S_JZ: begin
                RF_Ra_Addr = f0;
                ALU_Sel    = ALU_PASS;
            end
            S_HALT: Halted = 1'b1;
            default: ;
        endcase
    end

    assign State     = state_q;
    assign NextState = state_d;
    assign PC_Out    = pc_q;
    assign I_Addr    = pc_q;
    assign IR_Out    = ir_q;

endmodule
